// File: rtl/sisc_pkg.sv
// Shared constants for the SISC core: opcodes, ALU selectors (MM field),
// status bit positions and control FSM states.
package sisc_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_ALUI = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] MM_ADD = 4'd0;
  localparam logic [3:0] MM_SUB = 4'd1;
  localparam logic [3:0] MM_AND = 4'd2;
  localparam logic [3:0] MM_OR  = 4'd3;
  localparam logic [3:0] MM_XOR = 4'd4;
  localparam logic [3:0] MM_NOT = 4'd5;
  localparam logic [3:0] MM_SHL = 4'd6;
  localparam logic [3:0] MM_SHR = 4'd7;
  localparam logic [3:0] MM_MUL = 4'd8;

  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
endpackage

// File: rtl/sisc_alu.sv
// Combinational SISC ALU: result plus {C,V,N,Z}. The multiplier only exists
// when SISC_CORE_MUL_EN is defined; otherwise MM=8 is an RS pass-through.
module sisc_alu
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        stat
);
  localparam int SH_W = $clog2(DATA_W);

  logic              sub;
  logic [DATA_W-1:0] bb;
  logic [DATA_W:0]   sum;
  logic              c, v;
`ifdef SISC_CORE_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    sub = (op == MM_SUB);
    bb  = sub ? ~b : b;
    // SUB is RS + ~B + 1, so carry means "no borrow"
    sum = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, sub};
`ifdef SISC_CORE_MUL_EN
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      MM_ADD, MM_SUB: begin
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] == bb[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      MM_AND: res = a & b;
      MM_OR:  res = a | b;
      MM_XOR: res = a ^ b;
      MM_NOT: res = ~a;
      MM_SHL: res = a << b[SH_W-1:0];
      MM_SHR: res = a >> b[SH_W-1:0];
`ifdef SISC_CORE_MUL_EN
      MM_MUL: begin
        res = prod[DATA_W-1:0];
        c   = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: res = a;
    endcase
    stat       = 4'b0;
    stat[ST_C] = c;
    stat[ST_V] = v;
    stat[ST_N] = res[DATA_W-1];
    stat[ST_Z] = (res == '0);
  end
endmodule

// File: rtl/sisc_core.sv
// Self-fetching multicycle SISC core: FETCH/DECODE/EXEC/WB/HALT control with
// inline PC, IR, register file and status. SISC_CORE_MUL_EN enables MUL (MM=8).
module sisc_core
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 16,
  parameter int PC_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  output logic [PC_W-1:0]   IMEM_ADDR,
  output logic              IMEM_REQ,
  input  logic [31:0]       IMEM_DATA,
  input  logic              IMEM_VALID,
  output logic [PC_W-1:0]   PC,
  output logic [3:0]        STAT,
  output logic              HALTED,
  output logic              WB_EN,
  output logic [3:0]        WB_ADDR,
  output logic [DATA_W-1:0] WB_DATA
);
  localparam int RI_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  state_t            state;
  logic [PC_W-1:0]   pc_q, pc_next;
  logic [31:0]       ir;
  logic [3:0]        stat_q;
  logic [DATA_W-1:0] a_q, b_q, b_sel, alu_res;
  logic [3:0]        alu_stat;
  logic [DATA_W-1:0] rf [REG_N];
  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [3:0]      opc, mm;
  logic [RI_W-1:0] rs, rt, rd;
  logic [15:0]     imm;
  logic            is_alu, taken;

  assign opc    = ir[31:28];
  assign mm     = ir[27:24];
  assign rs     = ir[20 +: RI_W];
  assign rt     = ir[16 +: RI_W];
  assign rd     = ir[12 +: RI_W];
  assign imm    = ir[15:0];
  assign is_alu = (opc == OP_ALU) || (opc == OP_ALUI);
  assign b_sel  = (opc == OP_ALUI) ? DATA_W'($signed(imm)) : b_q;

  sisc_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a_q), .b(b_sel), .op(mm), .res(alu_res), .stat(alu_stat)
  );

  always_comb begin
    taken   = (mm == 4'd0) || ((stat_q & mm) != 4'd0);
    pc_next = pc_q + PC_W'(1);
    if (taken && opc == OP_BRA)      pc_next = PC_W'(imm);
    else if (taken && opc == OP_BRR) pc_next = pc_q + PC_W'(1) + PC_W'($signed(imm));
  end

  // Request is gated by reset so it is low while held in reset yet high in
  // the very first cycle after release.
  assign IMEM_REQ  = (state == S_FETCH) && RST_F;
  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign STAT      = stat_q;
  assign HALTED    = (state == S_HALT);
  assign WB_EN     = wb_en;
  assign WB_ADDR   = wb_addr;
  assign WB_DATA   = wb_data;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state   <= S_FETCH;
      pc_q    <= '0;
      ir      <= '0;
      stat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      wb_en <= 1'b0;
      unique case (state)
        S_FETCH: if (IMEM_VALID) begin
          ir    <= IMEM_DATA;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q   <= (rs == '0) ? '0 : rf[rs];
          b_q   <= (rt == '0) ? '0 : rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_alu) begin
            stat_q  <= alu_stat;
            wb_en   <= (rd != '0);
            wb_addr <= 4'(rd);
            wb_data <= alu_res;
          end
          state <= S_WB;
        end
        S_WB: begin
          if (wb_en) rf[rd] <= wb_data;
          pc_q  <= pc_next;
          state <= (opc == OP_HLT) ? S_HALT : S_FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sisc_core.sv
// Directed + random bench for sisc_core against an instruction-level model
// that tracks architectural registers, PC and status.
module tb_sisc_core;
  logic        CLK = 1'b0;
  logic        RST_F;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic [31:0] IMEM_DATA;
  logic        IMEM_VALID;
  logic [15:0] PC;
  logic [3:0]  STAT;
  logic        HALTED;
  logic        WB_EN;
  logic [3:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  sisc_core #(.DATA_W(32), .REG_N(16), .PC_W(16)) dut (
    .CLK(CLK), .RST_F(RST_F), .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
    .IMEM_DATA(IMEM_DATA), .IMEM_VALID(IMEM_VALID), .PC(PC), .STAT(STAT),
    .HALTED(HALTED), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [16];
  logic [15:0] m_pc;
  logic [3:0]  m_stat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pc   = '0;
    m_stat = '0;
  endtask

  task automatic do_reset();
    RST_F = 1'b0; IMEM_VALID = 1'b0; IMEM_DATA = '0;
    @(negedge CLK); #1;
    chk("rst_req", IMEM_REQ, 0);   chk("rst_pc", PC, 0);
    chk("rst_stat", STAT, 0);      chk("rst_halt", HALTED, 0);
    chk("rst_wben", WB_EN, 0);     chk("rst_wbaddr", WB_ADDR, 0);
    chk("rst_wbdata", WB_DATA, 0);
    model_reset();
    @(negedge CLK); RST_F = 1'b1; #1;
    chk("rel_req", IMEM_REQ, 1);   chk("rel_addr", IMEM_ADDR, 0);
  endtask

  // Expects to be called while the core sits in FETCH, away from a rising edge.
  task automatic run_instr(input logic [31:0] ins, input int waits);
    logic [3:0]  op, mm, rs, rt, rd;
    logic [15:0] imm, pc0, npc;
    logic [31:0] a, b, r;
    logic [63:0] t;
    longint      sr;
    logic        c, v, wr, taken;
    int          n, wb_seen;
    logic [3:0]  obs_addr;
    logic [31:0] obs_data;
    op = ins[31:28]; mm = ins[27:24]; rs = ins[23:20]; rt = ins[19:16];
    rd = ins[15:12]; imm = ins[15:0];
    a  = m_reg[rs];
    b  = (op == 4'd2) ? {{16{imm[15]}}, imm} : m_reg[rt];
    pc0 = m_pc; wr = 1'b0; r = '0; c = 1'b0; v = 1'b0;
    if (op == 4'd1 || op == 4'd2) begin
      case (mm)
        4'd0: begin
          r = a + b; t = 64'(a) + 64'(b); c = (t >= 64'h1_0000_0000);
          sr = longint'($signed(a)) + longint'($signed(b));
          v = (sr > longint'(32'sh7FFF_FFFF)) || (sr < -longint'(64'h8000_0000));
        end
        4'd1: begin
          r = a - b; c = (a >= b);
          sr = longint'($signed(a)) - longint'($signed(b));
          v = (sr > longint'(32'sh7FFF_FFFF)) || (sr < -longint'(64'h8000_0000));
        end
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = ~a;
        4'd6: r = a << (b % 32);
        4'd7: r = a >> (b % 32);
`ifdef SISC_CORE_MUL_EN
        4'd8: begin t = 64'(a) * 64'(b); r = t[31:0]; c = (t > 64'hFFFF_FFFF); end
`endif
        default: r = a;
      endcase
      m_stat = {c, v, r[31], r == 32'd0};
      wr = (rd != 4'd0);
      if (wr) m_reg[rd] = r;
    end
    taken = (mm == 4'd0) || ((m_stat & mm) != 4'd0);
    npc = pc0 + 16'd1;
    if (op == 4'd4 && taken) npc = imm;
    if (op == 4'd5 && taken) npc = pc0 + 16'd1 + imm;
    m_pc = npc;

    chk("fetch_req", IMEM_REQ, 1);
    chk("fetch_addr", IMEM_ADDR, pc0);
    for (int w = 0; w < waits; w++) begin
      IMEM_VALID = 1'b0; IMEM_DATA = $urandom;
      @(negedge CLK);
      chk("addr_hold", IMEM_ADDR, pc0);
    end
    IMEM_VALID = 1'b1; IMEM_DATA = ins;
    n = 0; wb_seen = 0; obs_addr = '0; obs_data = '0;
    do begin
      @(negedge CLK); n++;
      // Junk on the fetch port outside FETCH must be ignored.
      IMEM_VALID = 1'($urandom_range(0, 1)); IMEM_DATA = $urandom;
      if (WB_EN) begin wb_seen++; obs_addr = WB_ADDR; obs_data = WB_DATA; end
    end while (!IMEM_REQ && !HALTED && n < 12);
    IMEM_VALID = 1'b0;
    chk("cycles", waits + n, 4 + waits);
    chk("wb_cnt", wb_seen, wr ? 1 : 0);
    if (wr) begin
      chk("wb_addr", obs_addr, rd);
      chk("wb_data", obs_data, r);
    end
    chk("pc", PC, m_pc);
    chk("stat", STAT, m_stat);
    chk("halted", HALTED, op == 4'd15);
  endtask

  logic [31:0] ins;
  int          cls;

  initial begin
    RST_F = 1'b0; IMEM_VALID = 1'b0; IMEM_DATA = '0;
    do_reset();

    run_instr(32'h2000_1005, 0);          // ADDI R1,R0,0x1005
    run_instr(32'h1111_3000, 0);          // SUB R3,R1,R1
    chk("sub_stat", STAT, 4'b1001);
    run_instr(32'h4100_0010, 0);          // BRA MM=1 -> 0x10
    chk("bra_pc", PC, 16'h0010);
    run_instr(32'h2000_FFFF, 0);          // R15 = -1
    run_instr(32'h27F0_F001, 0);          // R15 >>= 1 -> 0x7FFFFFFF
    run_instr(32'h2710_100C, 1);          // R1 = 0x1005 >> 12 = 1
    run_instr(32'h10F1_2000, 0);          // ADD R2,R15,R1
    chk("ovf_data", m_reg[2], 32'h8000_0000);
    chk("ovf_stat", STAT, 4'b0110);
    run_instr(32'h2000_0007, 0);          // ADDI R0,R0,7: no write
    run_instr(32'h1000_5000, 0);          // ADD R5,R0,R0 reads 0
    run_instr(32'h1021_4000, 3);          // 3 fetch wait cycles

    // Multiplier corner: 0x10000 * 0x10000
    run_instr(32'h2000_1000, 0);
    run_instr(32'h2610_1004, 0);
    run_instr(32'h2000_2000, 2);
    run_instr(32'h2620_2003, 0);
    run_instr(32'h1812_3000, 0);
`ifdef SISC_CORE_MUL_EN
    chk("mul_data", m_reg[3], 32'h0);
    chk("mul_stat", STAT, 4'b1001);
`else
    chk("mul_data", m_reg[3], 32'h0001_0000);
`endif

    // Reset mid-FETCH discards the pending fetch.
    IMEM_VALID = 1'b0;
    @(negedge CLK); #2; RST_F = 1'b0; #1;
    chk("mf_pc", PC, 0); chk("mf_stat", STAT, 0); chk("mf_req", IMEM_REQ, 0);
    model_reset();
    @(negedge CLK); RST_F = 1'b1; #1;
    chk("mf_addr", IMEM_ADDR, 0);
    run_instr(32'h5000_FFFF, 1);          // BRR -1 at PC 0 -> PC 0
    chk("brr_pc", PC, 16'h0000);

    for (int k = 0; k < 80; k++) begin
      ins = $urandom;
      cls = $urandom_range(0, 9);
      if (cls < 6) begin
        ins[31:28] = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'd2;
        if ($urandom_range(0, 1) == 1) ins[27:24] = 4'($urandom_range(0, 8));
      end else if (cls < 8) begin
        ins[31:28] = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'd5;
      end else begin
        ins[31:28] = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(6, 14));
      end
      run_instr(ins, $urandom_range(0, 2));
    end

    run_instr(32'hF000_0000, 0);          // HLT
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      IMEM_VALID = 1'($urandom_range(0, 1));
      chk("halt_req", IMEM_REQ, 0);
      chk("halt_hi", HALTED, 1);
    end
    #2; RST_F = 1'b0; #1;
    chk("mh_pc", PC, 0); chk("mh_stat", STAT, 0); chk("mh_halt", HALTED, 0);
    model_reset();
    IMEM_VALID = 1'b0;
    @(negedge CLK); RST_F = 1'b1; #1;
    chk("mh_addr", IMEM_ADDR, 0);
    run_instr(32'h2000_3009, 0);
    run_instr(32'h1330_4000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
